// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard detection for the D stage of a five-stage pipeline.
// Register hazards compare D-stage source registers against the E/M
// destinations using Tuse/Tnew timing. A small FSM tracks the multi-cycle
// mult/div unit, and a saturating counter records stalled cycles.
//
// Start protocol: E_md_start is a single-cycle pulse from E. It is accepted
// only when the unit is IDLE, and E_md_div is sampled in that same cycle.
// A pulse that arrives while BUSY is dropped.
module pipe_stall_ctrl #(
    parameter int unsigned MULT_CYC = 5,   // 1..15
    parameter int unsigned DIV_CYC  = 10   // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic [4:0]  E_wa,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  E_Tnew,
    input  logic [1:0]  M_Tnew,
    input  logic        D_is_md,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_flush,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_cnt,
    output logic        dbg_state,     // 1 = mult/div FSM in BUSY
    output logic [3:0]  dbg_cnt        // mult/div down-counter
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    md_state_t  state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       stall_rs, stall_rt, stall_md, stall_raw;

    // Register hazards: a source is read too early if the producer's result
    // arrives later than the consumer needs it. $zero never stalls.
    always_comb begin
        stall_rs = (D_rs != 5'd0) &&
                   (((D_rs == E_wa) && (E_Tnew > D_Tuse_rs)) ||
                    ((D_rs == M_wa) && (M_Tnew > D_Tuse_rs)));
        stall_rt = (D_rt != 5'd0) &&
                   (((D_rt == E_wa) && (E_Tnew > D_Tuse_rt)) ||
                    ((D_rt == M_wa) && (M_Tnew > D_Tuse_rt)));
    end

    // Unit occupancy and the combined stall. Reset masks every request so the
    // pipeline runs freely while reset is held.
    always_comb begin
        md_busy   = ~reset & (E_md_start | (state == BUSY));
        stall_md  = D_is_md & md_busy;
        stall_raw = stall_rs | stall_rt | stall_md;
        stall     = ~reset & stall_raw;
        pc_en     = ~stall;
        fd_en     = ~stall;
        de_flush  = stall;
        dbg_state = (state == BUSY);
        dbg_cnt   = cnt;
    end

    // Mult/div FSM next state: load the latency on start, count down while BUSY.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (E_md_start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = E_md_div ? DIV_LD : MULT_LD;
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Mult/div FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Stalled-cycle counter; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
